matrix_scan_pwm: RTL and testbench

Parametrised, double-buffered LED matrix scanner, successor to the fixed 8×8 column scanner in the display path. Drives a ROWS×COLS matrix one column at a time with programmable dwell, anti-ghosting blank interval and per-column PWM brightness. A frame-load handshake swaps new pixel data in only at frame boundaries, so a frame is never torn. Sits between the pattern/sequence generator and the matrix pins.

---
 rtl/matrix_scan_pwm.sv | 187 ++++++++++++++++++
 tb/tb_matrix_scan_pwm.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_pwm.sv
// matrix_scan_pwm: double-buffered ROWSxCOLS LED column scanner with blanking.
// Per-column PWM brightness gating is built only when MATRIX_SCAN_PWM_EN is defined.
module matrix_scan_pwm #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int DWELL       = 16,
    parameter int BLANK_TICKS = 1,
    parameter int BW          = 5
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   CE,
    input  logic [ROWS*COLS-1:0]   FRAME,
    input  logic                   LOAD,
    input  logic [BW-1:0]          BRIGHT,
    output logic [ROWS-1:0]        ROW,
    output logic [COLS-1:0]        COL,
    output logic                   BUSY,
    output logic                   FRAME_SYNC
);

    localparam int N    = ROWS * COLS;
    localparam int TMAX = (DWELL > BLANK_TICKS) ? DWELL : BLANK_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [TW-1:0] T_SCAN_LAST  = TW'(DWELL - 1);
    localparam logic [TW-1:0] T_BLANK_LAST =
        TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [CW-1:0] C_LAST       = CW'(COLS - 1);
    localparam logic [TW-1:0] T_ONE        = TW'(1);
    localparam logic [CW-1:0] C_ONE        = CW'(1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_t;

    // With no blank interval the scanner lives permanently in SCAN.
    localparam state_t ST_RESET = (BLANK_TICKS > 0) ? ST_BLANK : ST_SCAN;

    state_t                    state;
    state_t                    nxt_state;
    logic [CW-1:0]             col;
    logic [CW-1:0]             nxt_col;
    logic [TW-1:0]             t;
    logic [TW-1:0]             nxt_t;

    logic [N-1:0]              front;
    logic [N-1:0]              back;
    logic [N-1:0]              nxt_front;
    logic                      busy;

    logic                      last_scan;
    logic                      boundary;
    logic                      swap;
    logic                      row_on;
    logic [COLS-1:0][ROWS-1:0] front_cols;

    // Scan sequencer state: advances only on CE ticks.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_RESET;
            col   <= '0;
            t     <= '0;
        end else if (CE) begin
            state <= nxt_state;
            col   <= nxt_col;
            t     <= nxt_t;
        end
    end

    // Next-state: dwell counting, column advance and blank insertion.
    always_comb begin
        nxt_state = state;
        nxt_col   = col;
        nxt_t     = t;
        last_scan = 1'b0;
        unique case (state)
            ST_BLANK: begin
                if (t == T_BLANK_LAST) begin
                    nxt_state = ST_SCAN;
                    nxt_t     = '0;
                end else begin
                    nxt_t = t + T_ONE;
                end
            end
            ST_SCAN: begin
                if (t == T_SCAN_LAST) begin
                    last_scan = 1'b1;
                    nxt_t     = '0;
                    nxt_col   = (col == C_LAST) ? '0 : col + C_ONE;
                    nxt_state = (BLANK_TICKS > 0) ? ST_BLANK : ST_SCAN;
                end else begin
                    nxt_t = t + T_ONE;
                end
            end
            default: begin
                nxt_state = ST_BLANK;
                nxt_t     = '0;
            end
        endcase
    end

    // The frame ends on the final dwell tick of the last column.
    assign boundary  = last_scan && (col == C_LAST);
    assign swap      = CE && boundary && busy;
    assign nxt_front = swap ? back : front;
    assign BUSY      = busy;

    // Front/back buffers: swap only at a frame boundary so frames never tear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            front <= '0;
            back  <= '0;
            busy  <= 1'b0;
        end else begin
            if (swap) begin
                front <= back;
            end
            if (LOAD) begin
                back <= FRAME;
                busy <= 1'b1;
            end else if (swap) begin
                busy <= 1'b0;
            end
        end
    end

    // Regroup the frame so each column's row bits are one vector;
    // pixel (0,0) sits at the MSB of FRAME.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign front_cols[c][r] =
                nxt_front[(ROWS - 1 - r) * COLS + (COLS - 1 - c)];
        end
    end

`ifdef MATRIX_SCAN_PWM_EN
    localparam int EW = (TW > BW) ? TW : BW;

    logic [BW-1:0] b;
    logic [BW-1:0] nxt_b;
    logic          enter_scan;

    assign enter_scan = (nxt_state == ST_SCAN) &&
                        ((state == ST_BLANK) || last_scan);

    // Brightness is sampled once per column so it never shifts mid-dwell.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            b <= '0;
        end else if (CE && enter_scan) begin
            b <= BRIGHT;
        end
    end

    assign nxt_b  = enter_scan ? BRIGHT : b;
    assign row_on = EW'(nxt_t) < EW'(nxt_b);
`else
    logic unused_bright;

    assign unused_bright = ^BRIGHT;
    assign row_on        = 1'b1;
`endif

    // Pin drive is registered from the post-tick state, so pins track the FSM.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ROW        <= '0;
            COL        <= '0;
            FRAME_SYNC <= 1'b0;
        end else begin
            FRAME_SYNC <= CE && boundary;
            if (CE) begin
                if (nxt_state == ST_SCAN) begin
                    ROW <= front_cols[nxt_col] & {ROWS{row_on}};
                    COL <= COLS'(1) << nxt_col;
                end else begin
                    ROW <= '0;
                    COL <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan_pwm.sv
// tb_matrix_scan_pwm: directed bench for matrix_scan_pwm.
// 8x8, DWELL=4, BLANK_TICKS=1, BW=3; PWM expectations follow MATRIX_SCAN_PWM_EN.
module tb_matrix_scan_pwm;

    localparam int ROWS        = 8;
    localparam int COLS        = 8;
    localparam int DWELL       = 4;
    localparam int BLANK_TICKS = 1;
    localparam int BW          = 3;
    localparam int PER         = DWELL + BLANK_TICKS;
    localparam int FR          = COLS * PER;

    localparam logic [63:0] FRM_A  = 64'h8000_0000_0000_0001;
    localparam logic [63:0] FRM_A2 = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] FRM_B  = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] FRM_C  = 64'h8080_8080_8080_8080;
    localparam logic [63:0] FRM_D  = 64'h0101_0101_0101_0101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic          load;
    logic [63:0]   frame;
    logic [BW-1:0] bright;
    logic [7:0]    row;
    logic [7:0]    col;
    logic          busy;
    logic          frame_sync;

    int total = 0;
    int bad   = 0;

    matrix_scan_pwm #(
        .ROWS(ROWS),
        .COLS(COLS),
        .DWELL(DWELL),
        .BLANK_TICKS(BLANK_TICKS),
        .BW(BW)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .CE(ce),
        .FRAME(frame),
        .LOAD(load),
        .BRIGHT(bright),
        .ROW(row),
        .COL(col),
        .BUSY(busy),
        .FRAME_SYNC(frame_sync)
    );

    always #5 clk = ~clk;

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Expected COL k CE ticks after a frame start (k=1 is first SCAN tick).
    function automatic logic [7:0] exp_col_at(input int k);
        if (k < 1) return 8'h00;
        if (((k - 1) % PER) >= DWELL) return 8'h00;
        return 8'(1 << (((k - 1) / PER) % COLS));
    endfunction

    function automatic int col_at(input int k);
        return ((k - 1) / PER) % COLS;
    endfunction

    function automatic int ph_at(input int k);
        return (k - 1) % PER;
    endfunction

    // Hand-derived column images of frame A (MSB=(0,0), LSB=(7,7)).
    function automatic logic [7:0] pat_a(input int c);
        return (c == 0) ? 8'h01 : ((c == 7) ? 8'h80 : 8'h00);
    endfunction

    task automatic test_reset();
        int hit;
        rst_n  = 1'b0;
        ce     = 1'b1;
        load   = 1'b0;
        frame  = '0;
        bright = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (row !== 8'h00) begin
            bad++;
            $display("FAIL reset_row got=%h want=00", row);
        end
        total++;
        if (col !== 8'h00) begin
            bad++;
            $display("FAIL reset_col got=%h want=00", col);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        total++;
        if (frame_sync !== 1'b0) begin
            bad++;
            $display("FAIL reset_sync got=%b want=0", frame_sync);
        end
        rst_n = 1'b1;
        hit = 0;
        for (int i = 1; i <= 60 && hit == 0; i++) begin
            edge1();
            if (frame_sync === 1'b1) hit = i;
        end
        total++;
        if (hit != FR) begin
            bad++;
            $display("FAIL reset_first_sync got=%0d want=%0d", hit, FR);
        end
    endtask

    task automatic test_load();
        logic [7:0] ec;
        logic [7:0] er;
        logic       eb;
        logic       es;
        frame  = FRM_A;
        bright = 3'd4;
        load   = 1'b1;
        for (int k = 1; k <= FR; k++) begin
            edge1();
            load = 1'b0;
            eb = (k < FR);
            es = (k == FR);
            total++;
            if (busy !== eb) begin
                bad++;
                $display("FAIL load_busy k=%0d got=%b want=%b", k, busy, eb);
            end
            total++;
            if (frame_sync !== es) begin
                bad++;
                $display("FAIL load_sync k=%0d got=%b want=%b",
                         k, frame_sync, es);
            end
            total++;
            if (row !== 8'h00) begin
                bad++;
                $display("FAIL load_dark k=%0d got=%h want=00", k, row);
            end
        end
        for (int k = 1; k <= FR; k++) begin
            edge1();
            ec = exp_col_at(k);
            er = (ec != 8'h00) ? pat_a(col_at(k)) : 8'h00;
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL show_col k=%0d got=%h want=%h", k, col, ec);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL show_row k=%0d got=%h want=%h", k, row, er);
            end
        end
    endtask

    task automatic test_pwm();
        logic [7:0] ec;
        logic [7:0] er;
        int         lim;
        bright = 3'd2;
        for (int k = 1; k <= FR; k++) begin
            edge1();
            if (k == 1) bright = 3'd4;
            ec = exp_col_at(k);
`ifdef MATRIX_SCAN_PWM_EN
            lim = (col_at(k) == 0) ? 2 : 4;
`else
            lim = 4;
`endif
            er = (ec != 8'h00 && ph_at(k) < lim) ? pat_a(col_at(k)) : 8'h00;
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL pwm_col k=%0d got=%h want=%h", k, col, ec);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL pwm_row k=%0d got=%h want=%h", k, row, er);
            end
        end
    endtask

    task automatic test_slow_ce();
        logic [7:0] ec;
        logic [7:0] er;
        logic       es;
        int         n;
        bright = 3'd4;
        for (int i = 1; i <= 3 * FR; i++) begin
            ce = ((i % 3) == 0);
            edge1();
            n  = i / 3;
            ec = exp_col_at(n);
            er = (ec != 8'h00) ? pat_a(col_at(n)) : 8'h00;
            es = (i == 3 * FR);
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL slow_col clk=%0d got=%h want=%h", i, col, ec);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL slow_row clk=%0d got=%h want=%h", i, row, er);
            end
            total++;
            if (frame_sync !== es) begin
                bad++;
                $display("FAIL slow_sync clk=%0d got=%b want=%b",
                         i, frame_sync, es);
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_overwrite();
        logic [7:0] ec;
        logic [7:0] er;
        logic       eb;
        logic       es;
        for (int k = 1; k <= FR; k++) begin
            if (k == 1) begin
                frame = FRM_A2;
                load  = 1'b1;
            end else if (k == 10) begin
                frame = FRM_B;
                load  = 1'b1;
            end else if (k == FR) begin
                frame = FRM_C;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            edge1();
            ec = exp_col_at(k);
            er = (ec != 8'h00) ? pat_a(col_at(k)) : 8'h00;
            es = (k == FR);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL ovw_busy k=%0d got=%b want=1", k, busy);
            end
            total++;
            if (frame_sync !== es) begin
                bad++;
                $display("FAIL ovw_sync k=%0d got=%b want=%b",
                         k, frame_sync, es);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL ovw_row k=%0d got=%h want=%h", k, row, er);
            end
        end
        load = 1'b0;
        for (int k = 1; k <= FR; k++) begin
            edge1();
            ec = exp_col_at(k);
            er = (ec != 8'h00) ? 8'h01 : 8'h00;
            eb = (k < FR);
            es = (k == FR);
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL coll_col k=%0d got=%h want=%h", k, col, ec);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL coll_row k=%0d got=%h want=%h", k, row, er);
            end
            total++;
            if (busy !== eb) begin
                bad++;
                $display("FAIL coll_busy k=%0d got=%b want=%b", k, busy, eb);
            end
            total++;
            if (frame_sync !== es) begin
                bad++;
                $display("FAIL coll_sync k=%0d got=%b want=%b",
                         k, frame_sync, es);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] ec;
        logic [7:0] er;
        logic       es;
        int         kk;
        for (int k = 1; k <= 17; k++) begin
            load = (k == 5);
            if (k == 5) frame = FRM_D;
            edge1();
            ec = exp_col_at(k);
            er = (ec != 8'h00 && col_at(k) == 0) ? 8'hFF : 8'h00;
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL c_row k=%0d got=%h want=%h", k, row, er);
            end
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL c_col k=%0d got=%h want=%h", k, col, ec);
            end
        end
        load  = 1'b0;
        rst_n = 1'b0;
        edge1();
        total++;
        if (row !== 8'h00 || col !== 8'h00) begin
            bad++;
            $display("FAIL midrst_pins got=%h/%h want=00/00", row, col);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_busy got=%b want=0", busy);
        end
        total++;
        if (frame_sync !== 1'b0) begin
            bad++;
            $display("FAIL midrst_sync got=%b want=0", frame_sync);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 2 * FR; k++) begin
            if (k == 3) begin
                frame = FRM_B;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            edge1();
            kk = ((k - 1) % FR) + 1;
            ec = exp_col_at(kk);
            er = (k > FR && ec != 8'h00) ? 8'h01 : 8'h00;
            es = (kk == FR);
            total++;
            if (col !== ec) begin
                bad++;
                $display("FAIL post_col k=%0d got=%h want=%h", k, col, ec);
            end
            total++;
            if (row !== er) begin
                bad++;
                $display("FAIL post_row k=%0d got=%h want=%h", k, row, er);
            end
            total++;
            if (frame_sync !== es) begin
                bad++;
                $display("FAIL post_sync k=%0d got=%b want=%b",
                         k, frame_sync, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pwm();
        test_slow_ce();
        test_overwrite();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
